// File: rtl/seg7_pkg.sv
// Shared constants and types for the six-digit seven-segment scan driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
// Used by seg7_scan_driver and bcd_to_seg7.
package seg7_pkg;

  localparam int NUM_DIGITS = 6;

  // Active-low segment patterns for BCD 0..9
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  // All segments dark, and the lone-g mark shown for non-BCD codes
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_ERR = 7'b0111111;

  // Digit position 0..5 (0 = seconds units, 5 = hours tens)
  typedef logic [2:0] idx_t;
  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder.
// Latency: 0 cycles (pure logic).
// Codes 10..15 decode to segment g only as a visible error mark.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Table lookup of the segment pattern for one digit
  always_comb begin
    seg_o = SEG_ERR;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_ERR;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Six-digit common-anode multiplexed display driver with per-frame digit snapshot.
// Latency: 1 clk from internal scan state to registered an/seg/dp outputs.
// No backpressure; optional blinking separator dp built when DP_BLINK_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  input  logic [3:0] m1,
  input  logic [3:0] m2,
  input  logic [3:0] h1,
  input  logic [3:0] h2,
  input  logic       tick,
  input  logic       blank,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [15:0] PCNT_MAX = 16'(SCAN_DIV - 1);
  localparam idx_t        IDX_MAX  = idx_t'(NUM_DIGITS - 1);

  logic [15:0]                pcnt_q, pcnt_d;
  idx_t                       idx_q, idx_d;
  bcd_t [NUM_DIGITS-1:0]      snap_q, snap_d;
  bcd_t [NUM_DIGITS-1:0]      digits_in;
  logic [5:0]                 an_q, an_d;
  logic [6:0]                 seg_q, seg_d;
  logic                       dp_q, dp_d;
  bcd_t                       cur_digit;
  logic [6:0]                 cur_pattern;
  logic                       slot_start;
  logic                       dead_cycle;

  // Element 0 is the seconds units digit, matching an[0]
  assign digits_in  = {h2, h1, m2, m1, s2, s1};
  assign dead_cycle = (pcnt_q == 16'd0);
  assign slot_start = dead_cycle && (idx_q == idx_t'(0));

  // Select the frozen digit for the slot currently being scanned
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == idx_t'(i)) cur_digit = snap_q[i];
    end
  end

  bcd_to_seg7 u_dec (
    .bcd_i (cur_digit),
    .seg_o (cur_pattern)
  );

  // Prescaler wrap advances the digit index; snapshot taken at the top of each frame
  always_comb begin
    pcnt_d = pcnt_q + 16'd1;
    idx_d  = idx_q;
    snap_d = snap_q;
    if (pcnt_q == PCNT_MAX) begin
      pcnt_d = 16'd0;
      idx_d  = (idx_q == IDX_MAX) ? idx_t'(0) : idx_q + idx_t'(1);
    end
    if (slot_start) snap_d = digits_in;
  end

`ifdef DP_BLINK_EN
  logic blink_q;

  // Separator blink flag flips once per seconds tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_q <= 1'b0;
    else if (tick) blink_q <= ~blink_q;
  end
`else
  logic unused_tick;
  assign unused_tick = tick;
`endif

  // Next output values: anodes dark in dead time or while blanked, seg/dp always track the scan
  always_comb begin
    an_d  = (blank || dead_cycle) ? 6'b111111 : ~(6'b000001 << idx_q);
    seg_d = cur_pattern;
`ifdef DP_BLINK_EN
    dp_d  = ~(blink_q && !dead_cycle &&
              (idx_q == idx_t'(2) || idx_q == idx_t'(4)));
`else
    dp_d  = 1'b1;
`endif
  end

  // Scan state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= 16'd0;
      idx_q  <= idx_t'(0);
      snap_q <= '0;
      an_q   <= 6'b111111;
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b1;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with a frame-arithmetic reference model.
// Drives directed scenarios followed by randomized digits/blank/tick traffic.
// Compares an/seg/dp every cycle against the model's expectation.
module tb_seg7_scan_driver;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] s1 = 0, s2 = 0, m1 = 0, m2 = 0, h1 = 0, h2 = 0;
  logic       tick = 1'b0;
  logic       blank = 1'b0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  // Model: n = clock edges since reset release; frozen digits; blink flag
  int         n;
  logic [3:0] m_snap [6];
  logic       m_blink;

  seg7_scan_driver #(.SCAN_DIV(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s1    (s1),
    .s2    (s2),
    .m1    (m1),
    .m2    (m2),
    .h1    (h1),
    .h2    (h2),
    .tick  (tick),
    .blank (blank),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (t=%0t n=%0d)", tag, got, exp, $time, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    m_blink = 1'b0;
    for (int i = 0; i < 6; i++) m_snap[i] = 4'd0;
  endtask

  // One clock: predict from the pre-edge model state, sample after the edge, advance model
  task automatic step();
    int p, ix;
    logic [3:0] cur [6];
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    p  = n % D;
    ix = (n / D) % 6;
    cur = '{s1, s2, m1, m2, h1, h2};
    e_an  = (blank || p == 0) ? 6'b111111 : ~(6'b000001 << ix);
    e_seg = ref_seg(m_snap[ix]);
`ifdef DP_BLINK_EN
    e_dp = !(m_blink && (ix == 2 || ix == 4) && p != 0);
`else
    e_dp = 1'b1;
`endif
    @(posedge clk);
    #1;
    check("an", {1'b0, an}, {1'b0, e_an});
    check("seg", seg, e_seg);
    check("dp", {6'd0, dp}, {6'd0, e_dp});
    if (p == 0 && ix == 0) m_snap = cur;
`ifdef DP_BLINK_EN
    if (tick) m_blink = ~m_blink;
`endif
    n++;
    tick = 1'b0;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic set_digits(input logic [3:0] a5, a4, a3, a2, a1, a0);
    h2 = a5; h1 = a4; m2 = a3; m1 = a2; s2 = a1; s1 = a0;
  endtask

  initial begin
    model_reset();
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);

    // Reset values while held in reset
    repeat (2) @(negedge clk);
    check("rst_an", {1'b0, an}, 7'b0111111);
    check("rst_seg", seg, 7'b1111111);
    check("rst_dp", {6'd0, dp}, 7'd1);
    rst_n = 1'b1;

    // First cycle dark, then digit 0 lit for D-1 cycles, then dead cycle
    step();
    check("first_dark", {1'b0, an}, 7'b0111111);
    step();
    check("digit0_lit", {1'b0, an}, 7'b0111110);
    run(2);
    step();
    check("dead_after0", {1'b0, an}, 7'b0111111);
    step();
    check("digit1_lit", {1'b0, an}, 7'b0111101);

    // Full frames with 1,2:3,4:5,6 held; spot-check h2 and s1 slots
    for (int i = 0; i < 2 * 6 * D; i++) begin
      step();
      if (an == 6'b011111) check("h2_is_1", seg, 7'b1111001);
      if (an == 6'b111110) check("s1_is_6", seg, 7'b0000010);
    end

    // Change s1 6->7 once the scan reaches idx 3: current frame keeps 6
    while (((n / D) % 6) != 3) step();
    s1 = 4'd7;
    while (((n / D) % 6) != 0 || (n % D) != 0) begin
      step();
      if (an == 6'b111110) check("s1_held_6", seg, 7'b0000010);
    end
    run(6 * D);
    for (int i = 0; i < 6 * D; i++) begin
      step();
      if (an == 6'b111110) check("s1_now_7", seg, 7'b1111000);
    end

    // Non-BCD code on s1 shows the error mark
    s1 = 4'hC;
    run(3 * 6 * D);

    // Blank for 10 cycles mid-slot; scan position must be unaffected
    run(D + 1);
    blank = 1'b1;
    step();
    check("blank_dark", {1'b0, an}, 7'b0111111);
    run(9);
    blank = 1'b0;
    run(2 * 6 * D);

    // Mid-frame asynchronous reset
    run(7);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_an", {1'b0, an}, 7'b0111111);
    check("mid_rst_seg", seg, 7'b1111111);
    check("mid_rst_dp", {6'd0, dp}, 7'd1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    set_digits(4'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd8);
    run(2 * 6 * D);

    // Two ticks 1000 cycles apart: separators lit in between, dark after
    tick = 1'b1;
    step();
    run(1000);
    tick = 1'b1;
    step();
    run(100);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0)
        set_digits($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) blank = ~blank;
      if ($urandom_range(0, 49) == 0) tick = 1'b1;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
